sr_boot_ctrl: RTL



---
 rtl/sr_boot_ctrl_pkg.sv | 19 +
 rtl/sr_word_asm.sv | 31 +++
 rtl/sr_boot_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/sr_boot_ctrl_pkg.sv
// rtl/sr_boot_ctrl_pkg.sv - shared state encodings and helpers for the boot/program-load controller
package sr_boot_ctrl_pkg;

   typedef logic [2:0] bootState_t;

   localparam bootState_t BOOT_LEN  = 3'd0;
   localparam bootState_t BOOT_LOAD = 3'd1;
   localparam bootState_t BOOT_WR   = 3'd2;
   localparam bootState_t BOOT_RUN  = 3'd3;
   localparam bootState_t BOOT_ERR  = 3'd4;

   // A length equal to the memory depth is legal; only strictly larger overflows.
   function automatic logic lenTooLong(input logic [31:0] len, input int addrW);
      logic [32:0] depth;
      depth = 33'd1 << addrW;
      return {1'b0, len} > depth;
   endfunction

endpackage

// File: rtl/sr_word_asm.sv
// rtl/sr_word_asm.sv - little-endian byte-to-word assembler with a 2-bit byte counter
module sr_word_asm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic [31:0] wordNext,
   output logic        wordDone
);

   logic [1:0]  cnt;
   logic [31:0] shiftReg;

   // Shifting right means the first byte ends up in [7:0] after four inserts.
   assign wordNext = {data, shiftReg[31:8]};
   assign wordDone = en & (cnt == 2'd3);
   assign word     = shiftReg;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt      <= 2'd0;
         shiftReg <= 32'd0;
      end else if (en) begin
         cnt      <= cnt + 2'd1;
         shiftReg <= wordNext;
      end
   end

endmodule

// File: rtl/sr_boot_ctrl.sv
// rtl/sr_boot_ctrl.sv - loads a byte stream into instruction memory, then releases the CPU and shares the memory port
module sr_boot_ctrl
   import sr_boot_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int AUTO_RUN = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              cpu_rst_n,
   input  logic [31:0]       cpu_imAddr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              busy,
   output logic              err
);

   localparam bootState_t RESET_STATE = (AUTO_RUN != 0) ? BOOT_RUN : BOOT_LEN;
   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   bootState_t      state;
   logic [ADDR_W:0] ptr;
   logic [ADDR_W:0] remaining;
   logic            accept;
   logic            asmClr;
   logic            wordDone;
   logic [31:0]     wordNext;
   logic [31:0]     word;
   logic            unusedImAddr;

   assign rx_ready  = (state == BOOT_LEN) || (state == BOOT_LOAD);
   assign accept    = rx_valid & rx_ready;
   assign asmClr    = ((state == BOOT_RUN) || (state == BOOT_ERR)) && load_req;
   assign busy      = (state == BOOT_LEN) || (state == BOOT_LOAD) || (state == BOOT_WR);
   assign err       = (state == BOOT_ERR);
   assign cpu_rst_n = (state == BOOT_RUN);
   assign mem_we    = (state == BOOT_WR);
   assign mem_wdata = word;
   // The CPU owns the address port only while running, with no register in the path.
   assign mem_addr  = (state == BOOT_RUN) ? cpu_imAddr[ADDR_W-1:0] : ptr[ADDR_W-1:0];
   assign unusedImAddr = ^cpu_imAddr[31:ADDR_W];

   sr_word_asm u_word_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (asmClr),
      .en       (accept),
      .data     (rx_data),
      .word     (word),
      .wordNext (wordNext),
      .wordDone (wordDone)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RESET_STATE;
         ptr       <= '0;
         remaining <= '0;
      end else begin
         case (state)
            BOOT_LEN: begin
               if (wordDone) begin
                  if (wordNext == 32'd0) begin
                     state <= BOOT_RUN;
                  end else if (lenTooLong(wordNext, ADDR_W)) begin
                     state <= BOOT_ERR;
                  end else begin
                     state     <= BOOT_LOAD;
                     ptr       <= '0;
                     remaining <= wordNext[ADDR_W:0];
                  end
               end
            end
            BOOT_LOAD: begin
               if (wordDone) state <= BOOT_WR;
            end
            BOOT_WR: begin
               ptr       <= ptr + ONE;
               remaining <= remaining - ONE;
               state     <= (remaining == ONE) ? BOOT_RUN : BOOT_LOAD;
            end
            BOOT_RUN, BOOT_ERR: begin
               if (load_req) begin
                  state <= BOOT_LEN;
                  ptr   <= '0;
               end
            end
            default: state <= BOOT_LEN;
         endcase
      end
   end

endmodule
